cache_mem_arbiter: RTL and testbench
====================================

Name: cache_mem_arbiter

Overview:
- Shares the single main-memory port between I-cache fill, D-cache fill and D-cache write-through stores.
- Sequences each 8-word block refill by issuing one word address per cycle, then steering the returned words into the requesting cache.
- Sits between the two caches and main memory.
- The pipeline stays frozen on any outstanding miss or store via the existing stall path.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width.
- WORDS_PER_BLK, 8, words per cache block (power of two; word-offset width = log2 of this).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- icache_miss  in  1  level; held until icache_fill_done.
- icache_miss_addr  in  ADDR_W  missing fetch address.
- dcache_miss  in  1  level; held until dcache_fill_done.
- dcache_miss_addr  in  ADDR_W  missing load/store address.
- dcache_wr_req  in  1  level; write-through store, held until dcache_wr_ack.
- dcache_wr_addr  in  ADDR_W  store address.
- dcache_wr_data  in  DATA_W  store data.
- mem_en  out  1  memory command valid.
- mem_wr  out  1  1 = write, 0 = read; meaningful only with mem_en.
- mem_addr  out  ADDR_W  command address.
- mem_wdata  out  DATA_W  write data.
- mem_rdata  in  DATA_W  read return data.
- mem_rvalid  in  1  read return valid; returns are in order and arrive a fixed number of cycles after issue.
- icache_fill_we  out  1  write fill_data into the I-cache data array.
- dcache_fill_we  out  1  write fill_data into the D-cache data array.
- fill_word  out  log2(WORDS_PER_BLK)  word index within the block.
- fill_data  out  DATA_W  registered copy of mem_rdata.
- icache_fill_done  out  1  one-cycle pulse with the last I-fill word; the cache writes tag/valid on this pulse.
- dcache_fill_done  out  1  same, for the D-cache.
- dcache_wr_ack  out  1  one-cycle pulse; store accepted by memory.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (synchronous, rst=1): state IDLE, all counters 0, every output 0. This applies mid-fill or mid-write too: the fill is aborted and no done or ack pulse is produced. Any mem_rvalid that arrives later, while in IDLE, is ignored.
- States: IDLE, WRITE, FILL_D, FILL_I.
- IDLE arbitration, fixed priority: dcache_wr_req > dcache_miss > icache_miss. D-side requests are older than the fetch.
  - On grant, latch the request address: block base = addr with the low log2(WORDS_PER_BLK)+1 bits cleared.
  - Move to the chosen state next cycle. No memory command is issued in the IDLE cycle.
- WRITE (exactly 1 cycle):
  - mem_en=1, mem_wr=1, mem_addr/mem_wdata = latched store address/data, dcache_wr_ack=1.
  - Next state IDLE.
- FILL_x:
  - Issue phase: issue_cnt runs 0..WORDS_PER_BLK-1, one read per cycle. mem_en=1, mem_wr=0, mem_addr = base + (issue_cnt<<1).
  - After the last issue, mem_en=0 while waiting.
  - Return phase: each mem_rvalid registers mem_rdata into fill_data, sets fill_word=recv_cnt, and pulses x_fill_we the following cycle.
  - recv_cnt increments per rvalid. Returns may overlap the issue phase.
  - When recv_cnt = WORDS_PER_BLK-1 is written, x_fill_done pulses in the same cycle as that final x_fill_we. The next state is IDLE; a new grant can be made there, and its first issue follows one cycle later.
- Only one of icache_fill_we / dcache_fill_we is ever asserted, and only in the matching state.
- Requests that drop early are not re-checked mid-operation; the current operation completes.
- Requests arriving while busy wait in IDLE arbitration. An I-miss can starve only while D-side traffic continues, which is bounded because the pipeline is stalled.
- Counters wrap at WORDS_PER_BLK and are cleared on entry to each FILL state.
- Latency, miss asserted at cycle 0 from IDLE:
  - first mem_en at cycle 1;
  - last issue at cycle 8;
  - done at last rvalid + 1.
- mem_addr and mem_wdata are 0 whenever mem_en=0.

Decomposition:
- Shared package cache_arb_pkg:
  - state enum (IDLE, WRITE, FILL_D, FILL_I);
  - WORDS_PER_BLK, offset-width constant, block-base mask function.
- One natural sub-module: blk_word_counter, a clear/enable/wrap counter with terminal-count output. It is instanced twice, for issue_cnt and recv_cnt.

Test Plan:
- dcache_miss=1, addr 0x1236; memory with 4-cycle latency:
  - mem_addr 0x1230, 0x1232, …, 0x123E on cycles 1–8;
  - dcache_fill_we with fill_word 0..7 matching data;
  - dcache_fill_done with word 7; busy drops the next cycle.
- icache_miss and dcache_miss asserted together:
  - D fill first, then I fill granted from IDLE, first I issue 1 cycle after that IDLE cycle;
  - no icache_fill_we during the D fill.
- dcache_wr_req (0x00A4, 0xBEEF) together with icache_miss:
  - one cycle with mem_en=1, mem_wr=1, addr 0x00A4, data 0xBEEF, ack=1;
  - then the I fill.
- rst pulsed at the 5th rvalid of a D fill:
  - outputs 0 the next cycle, no done pulse;
  - remaining rvalids ignored, no fill_we;
  - a subsequent miss refills from word 0.
- Stray mem_rvalid in IDLE with no request:
  - no fill_we, busy stays 0.
- Back-to-back D misses to 0x0000 then 0xFFF0:
  - the second block's addresses run 0xFFF0..0xFFFE with no wrap into the next block;
  - word indices restart at 0.

Source files
------------

// File: rtl/cache_mem_arbiter_pkg.sv
// rtl/cache_mem_arbiter_pkg.sv - shared types and block geometry for the cache/memory arbiter
package cache_arb_pkg;

  localparam int WORDS_PER_BLK = 8;
  localparam int BLK_OFF_W     = $clog2(WORDS_PER_BLK);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    FILL_D = 2'd2,
    FILL_I = 2'd3
  } arb_state_e;

  // Clears the byte-in-word bit plus the word-offset bits of an address.
  function automatic logic [31:0] blk_base_mask(input int off_w);
    return ~((32'd1 << (off_w + 1)) - 32'd1);
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// rtl/cache_mem_arbiter_if.sv - main-memory command/return port
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_rvalid;

  modport master (
    output mem_en, mem_wr, mem_addr, mem_wdata,
    input  mem_rdata, mem_rvalid
  );

  modport slave (
    input  mem_en, mem_wr, mem_addr, mem_wdata,
    output mem_rdata, mem_rvalid
  );
endinterface

// File: rtl/cache_mem_arbiter_blk_word_counter.sv
// rtl/cache_mem_arbiter_blk_word_counter.sv - word-within-block counter with clear and terminal count
module blk_word_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  // Block size is a power of two, so natural overflow is the wrap.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = (cnt == '1);

endmodule

// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - shares main memory between I-fill, D-fill and D write-through
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int WORDS_PER_BLK = cache_arb_pkg::WORDS_PER_BLK
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             icache_miss,
  input  logic [ADDR_W-1:0]                icache_miss_addr,
  input  logic                             dcache_miss,
  input  logic [ADDR_W-1:0]                dcache_miss_addr,
  input  logic                             dcache_wr_req,
  input  logic [ADDR_W-1:0]                dcache_wr_addr,
  input  logic [DATA_W-1:0]                dcache_wr_data,
  cache_mem_arbiter_if.master              mem,
  output logic                             icache_fill_we,
  output logic                             dcache_fill_we,
  output logic [$clog2(WORDS_PER_BLK)-1:0] fill_word,
  output logic [DATA_W-1:0]                fill_data,
  output logic                             icache_fill_done,
  output logic                             dcache_fill_done,
  output logic                             dcache_wr_ack,
  output logic                             busy
);

  localparam int                OFF_W     = $clog2(WORDS_PER_BLK);
  localparam logic [ADDR_W-1:0] BASE_MASK = ADDR_W'(blk_base_mask(OFF_W));

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              issue_done_q;
  logic              ifill_we_q, dfill_we_q;
  logic              ifill_done_q, dfill_done_q;
  logic [OFF_W-1:0]  fill_word_q;
  logic [DATA_W-1:0] fill_data_q;

  logic [OFF_W-1:0]  issue_cnt, recv_cnt;
  logic              issue_tc, recv_tc;
  logic              is_fill, issue_en, recv_en, cnt_clr;

  assign is_fill  = (state_q == FILL_D) || (state_q == FILL_I);
  assign issue_en = is_fill && !issue_done_q;
  // Once the done pulse is out the block is complete; later returns are not ours.
  assign recv_en  = is_fill && mem.mem_rvalid && !(ifill_done_q || dfill_done_q);
  assign cnt_clr  = (state_q == IDLE);

  blk_word_counter #(.WIDTH(OFF_W)) u_issue_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (issue_en),
    .cnt (issue_cnt),
    .tc  (issue_tc)
  );

  blk_word_counter #(.WIDTH(OFF_W)) u_recv_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (recv_en),
    .cnt (recv_cnt),
    .tc  (recv_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      base_q       <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      issue_done_q <= 1'b0;
      ifill_we_q   <= 1'b0;
      dfill_we_q   <= 1'b0;
      ifill_done_q <= 1'b0;
      dfill_done_q <= 1'b0;
      fill_word_q  <= '0;
      fill_data_q  <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == IDLE) begin
        if (dcache_wr_req) begin
          waddr_q <= dcache_wr_addr;
          wdata_q <= dcache_wr_data;
        end else if (dcache_miss) begin
          base_q <= dcache_miss_addr & BASE_MASK;
        end else if (icache_miss) begin
          base_q <= icache_miss_addr & BASE_MASK;
        end
      end

      if (state_q == IDLE) begin
        issue_done_q <= 1'b0;
      end else if (issue_en && issue_tc) begin
        issue_done_q <= 1'b1;
      end

      dfill_we_q   <= recv_en && (state_q == FILL_D);
      ifill_we_q   <= recv_en && (state_q == FILL_I);
      dfill_done_q <= recv_en && recv_tc && (state_q == FILL_D);
      ifill_done_q <= recv_en && recv_tc && (state_q == FILL_I);
      if (recv_en) begin
        fill_data_q <= mem.mem_rdata;
        fill_word_q <= recv_cnt;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    mem.mem_en    = 1'b0;
    mem.mem_wr    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    dcache_wr_ack = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (dcache_wr_req)    state_d = WRITE;
        else if (dcache_miss) state_d = FILL_D;
        else if (icache_miss) state_d = FILL_I;
      end
      WRITE: begin
        mem.mem_en    = 1'b1;
        mem.mem_wr    = 1'b1;
        mem.mem_addr  = waddr_q;
        mem.mem_wdata = wdata_q;
        dcache_wr_ack = 1'b1;
        state_d       = IDLE;
      end
      FILL_D, FILL_I: begin
        if (issue_en) begin
          mem.mem_en   = 1'b1;
          mem.mem_addr = base_q | ADDR_W'({issue_cnt, 1'b0});
        end
        if (ifill_done_q || dfill_done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign icache_fill_we   = ifill_we_q;
  assign dcache_fill_we   = dfill_we_q;
  assign icache_fill_done = ifill_done_q;
  assign dcache_fill_done = dfill_done_q;
  assign fill_word        = fill_word_q;
  assign fill_data        = fill_data_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed bench for cache_mem_arbiter with a 4-cycle-latency memory
module tb_cache_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        icache_miss;
  logic [15:0] icache_miss_addr;
  logic        dcache_miss;
  logic [15:0] dcache_miss_addr;
  logic        dcache_wr_req;
  logic [15:0] dcache_wr_addr;
  logic [15:0] dcache_wr_data;
  logic        icache_fill_we;
  logic        dcache_fill_we;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        icache_fill_done;
  logic        dcache_fill_done;
  logic        dcache_wr_ack;
  logic        busy;

  cache_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) mem_bus ();

  cache_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WORDS_PER_BLK(8)) dut (
    .clk              (clk),
    .rst              (rst),
    .icache_miss      (icache_miss),
    .icache_miss_addr (icache_miss_addr),
    .dcache_miss      (dcache_miss),
    .dcache_miss_addr (dcache_miss_addr),
    .dcache_wr_req    (dcache_wr_req),
    .dcache_wr_addr   (dcache_wr_addr),
    .dcache_wr_data   (dcache_wr_data),
    .mem              (mem_bus),
    .icache_fill_we   (icache_fill_we),
    .dcache_fill_we   (dcache_fill_we),
    .fill_word        (fill_word),
    .fill_data        (fill_data),
    .icache_fill_done (icache_fill_done),
    .dcache_fill_done (dcache_fill_done),
    .dcache_wr_ack    (dcache_wr_ack),
    .busy             (busy)
  );

  int          tests = 0;
  int          fails = 0;
  logic        pv [0:3];
  logic [15:0] pa [0:3];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; the memory returns each read 4 cycles after issue.
  task automatic step();
    @(posedge clk);
    #1;
    mem_bus.mem_rvalid = pv[0];
    mem_bus.mem_rdata  = pv[0] ? (pa[0] ^ 16'hA5A5) : 16'h0000;
    for (int k = 0; k < 3; k++) begin
      pv[k] = pv[k+1];
      pa[k] = pa[k+1];
    end
    pv[3] = mem_bus.mem_en && !mem_bus.mem_wr;
    pa[3] = mem_bus.mem_addr;
  endtask

  // Current cycle must be IDLE; leaves the bench in the IDLE cycle after done.
  task automatic do_fill(input bit is_d, input logic [15:0] addr);
    logic [15:0] base;
    logic        we_exp;
    base = addr & 16'hFFF0;
    if (is_d) begin
      dcache_miss = 1'b1; dcache_miss_addr = addr;
    end else begin
      icache_miss = 1'b1; icache_miss_addr = addr;
    end
    chk("grant_busy", busy, 0);
    chk("grant_en", mem_bus.mem_en, 0);
    for (int c = 1; c <= 14; c++) begin
      step();
      we_exp = (c >= 6) && (c <= 13);
      chk("fill_en", mem_bus.mem_en, (c <= 8));
      chk("fill_addr", mem_bus.mem_addr, (c <= 8) ? 32'(base + 16'(2 * (c - 1))) : 32'h0);
      chk("fill_wr", mem_bus.mem_wr, 0);
      chk("fill_wdata", mem_bus.mem_wdata, 0);
      chk("d_we", dcache_fill_we, is_d && we_exp);
      chk("i_we", icache_fill_we, !is_d && we_exp);
      if (we_exp) begin
        chk("fill_word", fill_word, c - 6);
        chk("fill_data", fill_data, (base + 16'(2 * (c - 6))) ^ 16'hA5A5);
      end
      chk("d_done", dcache_fill_done, is_d && (c == 13));
      chk("i_done", icache_fill_done, !is_d && (c == 13));
      chk("fill_busy", busy, (c <= 13));
      if (c == 13) begin
        if (is_d) dcache_miss = 1'b0;
        else      icache_miss = 1'b0;
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    icache_miss = 1'b0; icache_miss_addr = '0;
    dcache_miss = 1'b0; dcache_miss_addr = '0;
    dcache_wr_req = 1'b0; dcache_wr_addr = '0; dcache_wr_data = '0;
    mem_bus.mem_rvalid = 1'b0; mem_bus.mem_rdata = '0;
    for (int k = 0; k < 4; k++) begin
      pv[k] = 1'b0; pa[k] = '0;
    end
    step();
    step();
    rst = 1'b0;
    chk("rst_en", mem_bus.mem_en, 0);
    chk("rst_addr", mem_bus.mem_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ack", dcache_wr_ack, 0);
    chk("rst_we", {icache_fill_we, dcache_fill_we}, 0);
    chk("rst_done", {icache_fill_done, dcache_fill_done}, 0);
    chk("rst_fill_data", fill_data, 0);
    chk("rst_fill_word", fill_word, 0);
    step();

    // Store beats a pending I-miss, then the I-fill is granted from IDLE.
    dcache_wr_req = 1'b1; dcache_wr_addr = 16'h00A4; dcache_wr_data = 16'hBEEF;
    icache_miss = 1'b1; icache_miss_addr = 16'h0456;
    chk("wr_idle_en", mem_bus.mem_en, 0);
    step();
    chk("wr_en", mem_bus.mem_en, 1);
    chk("wr_wr", mem_bus.mem_wr, 1);
    chk("wr_addr", mem_bus.mem_addr, 16'h00A4);
    chk("wr_data", mem_bus.mem_wdata, 16'hBEEF);
    chk("wr_ack", dcache_wr_ack, 1);
    chk("wr_busy", busy, 1);
    dcache_wr_req = 1'b0;
    step();
    chk("wr_ack_drop", dcache_wr_ack, 0);
    chk("wr_after_en", mem_bus.mem_en, 0);
    chk("wr_after_busy", busy, 0);
    do_fill(1'b0, 16'h0456);

    // Simultaneous misses: D first, then I.
    dcache_miss = 1'b1; dcache_miss_addr = 16'h1236;
    icache_miss = 1'b1; icache_miss_addr = 16'h3008;
    do_fill(1'b1, 16'h1236);
    do_fill(1'b0, 16'h3008);

    // Stray return with nothing outstanding.
    mem_bus.mem_rvalid = 1'b1; mem_bus.mem_rdata = 16'h1234;
    step();
    chk("stray_d_we", dcache_fill_we, 0);
    chk("stray_i_we", icache_fill_we, 0);
    chk("stray_busy", busy, 0);

    // Reset at the 5th return of a D-fill.
    dcache_miss = 1'b1; dcache_miss_addr = 16'h2000;
    for (int c = 1; c <= 9; c++) step();
    chk("pre_rst_we", dcache_fill_we, 1);
    rst = 1'b1;
    dcache_miss = 1'b0;
    step();
    rst = 1'b0;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_en", mem_bus.mem_en, 0);
    chk("post_rst_we", dcache_fill_we, 0);
    chk("post_rst_done", dcache_fill_done, 0);
    chk("post_rst_data", fill_data, 0);
    chk("post_rst_word", fill_word, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("late_rv_we", {icache_fill_we, dcache_fill_we}, 0);
      chk("late_rv_done", {icache_fill_done, dcache_fill_done}, 0);
      chk("late_rv_busy", busy, 0);
    end
    do_fill(1'b1, 16'h2004);

    // Back-to-back D misses, second one at the top of the address space.
    do_fill(1'b1, 16'h0000);
    do_fill(1'b1, 16'hFFF0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
